// File: rtl/qq_sched_pkg.sv
// Shared types for the qq_sched queue-access scheduler: FSM states, op codes
// and a saturating counter helper.
package qq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OP_ENQ = 1'b0,
        OP_DEQ = 1'b1
    } op_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/qq_sched_if.sv
// Requester and queue-side signal bundle for qq_sched; the scheduler uses the
// slave modport, the requesters/queue environment the master modport.
interface qq_sched_if #(
    parameter int W = 32,
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_op;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           q_enq;
    logic           q_deq;
    logic [W-1:0]   q_data_o;
    logic [W-1:0]   q_data_i;
    logic           q_full;
    logic           q_empty;
    logic           q_rdy;

    modport master (
        output req_valid, req_op, req_data, q_data_i, q_full, q_empty, q_rdy,
        input  gnt, rsp_valid, rsp_data, q_enq, q_deq, q_data_o
    );

    modport slave (
        input  req_valid, req_op, req_data, q_data_i, q_full, q_empty, q_rdy,
        output gnt, rsp_valid, rsp_data, q_enq, q_deq, q_data_o
    );
endinterface

// File: rtl/qq_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module qq_rr_arb #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] id,
    output logic           any
);

    int   idx_s;
    logic hit_s;

    // Rotating priority search; once a hit is found later candidates are masked
    always_comb begin
        gnt   = '0;
        id    = '0;
        any   = 1'b0;
        idx_s = 0;
        hit_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
            hit_s = !any && (|(req & (N'(1) << idx_s)));
            gnt   = gnt | (hit_s ? (N'(1) << idx_s) : N'(0));
            id    = hit_s ? IDW'(idx_s) : id;
            any   = any | hit_s;
        end
    end

endmodule

// File: rtl/qq_sched.sv
// Round-robin scheduler granting N requesters one at a time onto a shared queue.
// Optional statistics counters are enabled with QQ_SCHED_STATS_EN.
module qq_sched
    import qq_pkg::*;
#(
    parameter int W   = 32,
    parameter int N   = 4,
    parameter int CAP = 8,
    localparam int CW = $clog2(CAP + 1)
) (
    input  logic          clk,
    input  logic          rst,
    qq_sched_if.slave     bus,
    output logic [CW-1:0] count
`ifdef QQ_SCHED_STATS_EN
    ,
    output logic [15:0]   stat_enq,
    output logic [15:0]   stat_deq,
    output logic [15:0]   stat_block
`endif
);

    localparam int IDW = $clog2(N);
    localparam logic [CW-1:0]  CAP_C   = CW'(CAP);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    state_t         state_r, state_s;
    op_t            op_r, op_s;
    logic [IDW-1:0] id_r, id_s, ptr_r, ptr_s;
    logic [CW-1:0]  count_r, count_s;
    logic [N-1:0]   gnt_r, gnt_s, rsp_valid_r, rsp_valid_s;
    logic           q_enq_r, q_enq_s, q_deq_r, q_deq_s;
    logic [W-1:0]   q_data_r, q_data_s, rsp_data_r, rsp_data_s;

    logic [N-1:0]   elig_s, arb_gnt_s;
    logic [IDW-1:0] arb_id_s;
    logic           arb_any_s, enq_ok_s, deq_ok_s;
    logic [W-1:0]   req_word_s [N];

    assign enq_ok_s = (count_r < CAP_C) && !bus.q_full;
    assign deq_ok_s = (count_r != '0) && !bus.q_empty;

    for (genvar i = 0; i < N; i++) begin : g_req
        assign req_word_s[i] = bus.req_data[i*W +: W];
        assign elig_s[i]     = bus.req_valid[i] && (bus.req_op[i] ? deq_ok_s : enq_ok_s);
    end

    qq_rr_arb #(.N(N)) u_arb (
        .req (elig_s),
        .ptr (ptr_r),
        .gnt (arb_gnt_s),
        .id  (arb_id_s),
        .any (arb_any_s)
    );

    // Next-state and next-output decode; outputs are registered alongside the state
    always_comb begin
        state_s     = state_r;
        id_s        = id_r;
        op_s        = op_r;
        ptr_s       = ptr_r;
        count_s     = count_r;
        gnt_s       = '0;
        q_enq_s     = 1'b0;
        q_deq_s     = 1'b0;
        q_data_s    = '0;
        rsp_valid_s = '0;
        rsp_data_s  = '0;
        case (state_r)
            IDLE: begin
                if (bus.q_rdy && arb_any_s) begin
                    state_s  = ISSUE;
                    id_s     = arb_id_s;
                    op_s     = op_t'(bus.req_op[arb_id_s]);
                    ptr_s    = (arb_id_s == LAST_ID) ? '0 : arb_id_s + IDW'(1);
                    gnt_s    = arb_gnt_s;
                    q_enq_s  = (op_s == OP_ENQ);
                    q_deq_s  = (op_s == OP_DEQ);
                    q_data_s = (op_s == OP_ENQ) ? req_word_s[arb_id_s] : '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
                // Occupancy is bounded here as well as by eligibility
                if (op_r == OP_ENQ) begin
                    count_s = (count_r != CAP_C) ? count_r + CW'(1) : count_r;
                end else begin
                    count_s = (count_r != '0) ? count_r - CW'(1) : count_r;
                end
            end
            WAIT: begin
                if (bus.q_rdy) begin
                    if (op_r == OP_DEQ) begin
                        state_s     = RESP;
                        rsp_valid_s = N'(1) << id_r;
                        rsp_data_s  = bus.q_data_i;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched op and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            id_r        <= '0;
            op_r        <= OP_ENQ;
            ptr_r       <= '0;
            count_r     <= '0;
            gnt_r       <= '0;
            q_enq_r     <= 1'b0;
            q_deq_r     <= 1'b0;
            q_data_r    <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            state_r     <= state_s;
            id_r        <= id_s;
            op_r        <= op_s;
            ptr_r       <= ptr_s;
            count_r     <= count_s;
            gnt_r       <= gnt_s;
            q_enq_r     <= q_enq_s;
            q_deq_r     <= q_deq_s;
            q_data_r    <= q_data_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.q_enq     = q_enq_r;
    assign bus.q_deq     = q_deq_r;
    assign bus.q_data_o  = q_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign count         = count_r;

`ifdef QQ_SCHED_STATS_EN
    logic [15:0] stat_enq_r, stat_deq_r, stat_block_r;
    logic        block_s;

    assign block_s = (state_r == IDLE) && (|(bus.req_valid & ~elig_s));

    // Saturating grant and blocked-cycle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_enq_r   <= 16'd0;
            stat_deq_r   <= 16'd0;
            stat_block_r <= 16'd0;
        end else begin
            stat_enq_r   <= q_enq_s ? sat_inc16(stat_enq_r) : stat_enq_r;
            stat_deq_r   <= q_deq_s ? sat_inc16(stat_deq_r) : stat_deq_r;
            stat_block_r <= block_s ? sat_inc16(stat_block_r) : stat_block_r;
        end
    end

    assign stat_enq   = stat_enq_r;
    assign stat_deq   = stat_deq_r;
    assign stat_block = stat_block_r;
`endif

endmodule

// File: tb/tb_qq_sched.sv
// Directed self-checking bench for qq_sched (W=32, N=4, CAP=8).
module tb_qq_sched;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int CAP = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] count;
`ifdef QQ_SCHED_STATS_EN
    logic [15:0]   stat_enq, stat_deq, stat_block;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    qq_sched_if #(.W(W), .N(N)) bus ();

    qq_sched #(.W(W), .N(N), .CAP(CAP)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .count (count)
`ifdef QQ_SCHED_STATS_EN
        ,
        .stat_enq   (stat_enq),
        .stat_deq   (stat_deq),
        .stat_block (stat_block)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic op, input logic [31:0] d);
        bus.req_valid[i]        = v;
        bus.req_op[i]           = op;
        bus.req_data[i*W +: W]  = d;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.q_data_i  = 32'h0;
        bus.q_full    = 1'b0;
        bus.q_empty   = 1'b0;
        bus.q_rdy     = 1'b1;
        tick();
        tick();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_q_enq", 32'(bus.q_enq), 32'h0);
        chk("rst_q_deq", 32'(bus.q_deq), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        rst = 1'b1;
        tick();

        // single enqueue from requester 0
        set_req(0, 1'b1, 1'b0, 32'hA5A5A5A5);
        tick();
        chk("a_gnt", 32'(bus.gnt), 32'h1);
        chk("a_q_enq", 32'(bus.q_enq), 32'h1);
        chk("a_q_data_o", bus.q_data_o, 32'hA5A5A5A5);
        chk("a_count_issue", 32'(count), 32'h0);
        set_req(0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("a_gnt_off", 32'(bus.gnt), 32'h0);
        chk("a_q_enq_off", 32'(bus.q_enq), 32'h0);
        chk("a_count", 32'(count), 32'h1);
        tick();

        // four simultaneous enqueues from reset
        rst = 1'b0;
        tick();
        chk("b_rst_count", 32'(count), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h100 + 32'(i));
        for (int k = 0; k < N; k++) begin
            tick();
            chk("b_gnt", 32'(bus.gnt), 32'h1 << k);
            chk("b_q_data_o", bus.q_data_o, 32'h100 + 32'(k));
            set_req(k, 1'b0, 1'b0, 32'h0);
            tick();
            chk("b_gnt_wait", 32'(bus.gnt), 32'h0);
            tick();
        end
        chk("b_count", 32'(count), 32'h4);

        // fill to capacity, then a blocked enqueue released by a dequeue
        for (int j = 0; j < 4; j++) begin
            set_req(0, 1'b1, 1'b0, 32'h200 + 32'(j));
            tick();
            chk("c_fill_gnt", 32'(bus.gnt), 32'h1);
            set_req(0, 1'b0, 1'b0, 32'h0);
            tick();
            tick();
        end
        chk("c_count_full", 32'(count), 32'h8);
        set_req(2, 1'b1, 1'b0, 32'hBEEF0002);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("c_full_nognt", 32'(bus.gnt), 32'h0);
        end
        set_req(1, 1'b1, 1'b1, 32'h0);
        bus.q_data_i = 32'hCAFE0001;
        tick();
        chk("c_deq_gnt", 32'(bus.gnt), 32'h2);
        chk("c_q_deq", 32'(bus.q_deq), 32'h1);
        chk("c_deq_q_data_o", bus.q_data_o, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("c_count_7", 32'(count), 32'h7);
        tick();
        chk("c_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("c_rsp_data", bus.rsp_data, 32'hCAFE0001);
        tick();
        chk("c_rsp_off", 32'(bus.rsp_valid), 32'h0);
        tick();
        chk("c_gnt_req2", 32'(bus.gnt), 32'h4);
        chk("c_q_data_req2", bus.q_data_o, 32'hBEEF0002);
        set_req(2, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("c_count_refull", 32'(count), 32'h8);

        // dequeue while empty is never granted
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("d_count", 32'(count), 32'h0);
        set_req(0, 1'b1, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("d_nognt", 32'(bus.gnt), 32'h0);
`ifdef QQ_SCHED_STATS_EN
            chk("d_stat_block", 32'(stat_block), 32'(k + 1));
`endif
        end
`ifdef QQ_SCHED_STATS_EN
        chk("d_stat_deq", 32'(stat_deq), 32'h0);
`endif
        set_req(0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("d_withdrawn", 32'(bus.gnt), 32'h0);

        // dequeue with a stalled queue
        set_req(3, 1'b1, 1'b0, 32'h33333333);
        tick();
        chk("e_enq_gnt", 32'(bus.gnt), 32'h8);
        set_req(3, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        set_req(2, 1'b1, 1'b1, 32'h0);
        bus.q_data_i = 32'h0;
        tick();
        chk("e_deq_gnt", 32'(bus.gnt), 32'h4);
        chk("e_q_deq", 32'(bus.q_deq), 32'h1);
        set_req(2, 1'b0, 1'b0, 32'h0);
        bus.q_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("e_stall_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        bus.q_rdy    = 1'b1;
        bus.q_data_i = 32'h12345678;
        tick();
        chk("e_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        chk("e_rsp_data", bus.rsp_data, 32'h12345678);
        tick();
        chk("e_rsp_off", 32'(bus.rsp_valid), 32'h0);
        chk("e_count", 32'(count), 32'h0);

        // asynchronous reset during WAIT
        set_req(1, 1'b1, 1'b0, 32'h11111111);
        tick();
        chk("f_gnt", 32'(bus.gnt), 32'h2);
        set_req(1, 1'b0, 1'b0, 32'h0);
        bus.q_rdy = 1'b0;
        tick();
        chk("f_count_wait", 32'(count), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("f_rst_count", 32'(count), 32'h0);
        chk("f_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("f_rst_q_enq", 32'(bus.q_enq), 32'h0);
        chk("f_rst_rsp", 32'(bus.rsp_valid), 32'h0);
        bus.q_rdy = 1'b1;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("f_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h400 + 32'(i));
        tick();
        chk("f_gnt_req0", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
